// File: rtl/oa_accum_writeback.sv
// Captures PE output-activation tiles, accumulates them across channel-group passes, then requantizes
// and streams the final tile one element per beat. Define OA_RELU_EN to clamp negative accumulators to 0.
module oa_accum_writeback #(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned CH     = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned SHIFT  = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_pe_finish,
  input  logic [ROWS*CH*DATA_W-1:0]       i_pe_oa,
  input  logic                            i_first,
  input  logic                            i_last,
  output logic                            o_busy,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic signed [OUT_W-1:0]         o_data,
  output logic [$clog2(ROWS*CH)-1:0]      o_idx,
  output logic                            o_done,
  output logic                            o_err
);

  localparam int unsigned N     = ROWS * CH;
  localparam int unsigned IDX_W = $clog2(N);

`ifdef OA_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACC   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  // Saturation bounds and rounding constant, all at ACC_W+1 bits
  localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'(1) << (SHIFT - 1);

  function automatic logic signed [ACC_W-1:0] sext_psum(input logic [DATA_W-1:0] p);
    return ACC_W'($signed(p));
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
    if (s > ACC_MAX)      s = ACC_MAX;
    else if (s < ACC_MIN) s = ACC_MIN;
    return ACC_W'(s);
  endfunction

  // Round-half-up shift then clamp; one extra bit keeps the rounding add from wrapping
  function automatic logic signed [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] t;
    t = (ACC_W+1)'(a);
    if (RELU_EN && t[ACC_W]) t = '0;
    t = (t + RND) >>> SHIFT;
    if (t > OUT_MAX)      t = OUT_MAX;
    else if (t < OUT_MIN) t = OUT_MIN;
    return OUT_W'(t);
  endfunction

  logic [1:0]                state_q, state_d;
  logic                      finish_q;
  logic [N*DATA_W-1:0]       psum_q, psum_d;
  logic                      first_q, first_d;
  logic                      last_q, last_d;
  logic signed [ACC_W-1:0]   acc_q [N];
  logic signed [ACC_W-1:0]   acc_d [N];
  logic                      busy_d, valid_d, done_d, err_d;
  logic signed [OUT_W-1:0]   data_d;
  logic [IDX_W-1:0]          idx_d;
  logic                      cap;

  assign cap = i_pe_finish & ~finish_q;

  // Next-state, datapath and output computation
  always_comb begin
    state_d = state_q;
    psum_d  = psum_q;
    first_d = first_q;
    last_d  = last_q;
    valid_d = o_valid;
    idx_d   = o_idx;
    data_d  = o_data;
    done_d  = 1'b0;
    err_d   = o_err;
    for (int k = 0; k < N; k++) acc_d[k] = acc_q[k];

    if (cap && (state_q != S_IDLE)) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cap) begin
          psum_d  = i_pe_oa;
          first_d = i_first;
          last_d  = i_last;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        for (int k = 0; k < N; k++) begin
          acc_d[k] = first_q ? sext_psum(psum_q[k*DATA_W +: DATA_W])
                             : sat_add(acc_q[k], sext_psum(psum_q[k*DATA_W +: DATA_W]));
        end
        if (last_q) begin
          state_d = S_DRAIN;
          valid_d = 1'b1;
          idx_d   = '0;
          data_d  = requant(acc_d[0]);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (o_valid && i_ready) begin
          if (o_idx == IDX_LAST) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d  = o_idx + IDX_W'(1);
            data_d = requant(acc_q[idx_d]);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      finish_q <= 1'b0;
      psum_q   <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      for (int k = 0; k < N; k++) acc_q[k] <= '0;
      o_busy   <= 1'b0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_idx    <= '0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      state_q  <= state_d;
      finish_q <= i_pe_finish;
      psum_q   <= psum_d;
      first_q  <= first_d;
      last_q   <= last_d;
      for (int k = 0; k < N; k++) acc_q[k] <= acc_d[k];
      o_busy   <= busy_d;
      o_valid  <= valid_d;
      o_data   <= data_d;
      o_idx    <= idx_d;
      o_done   <= done_d;
      o_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_oa_accum_writeback.sv
// Directed bench for oa_accum_writeback: single/multi pass tiles, rounding and saturation corners,
// backpressure, capture-while-busy error and mid-drain reset.
module tb_oa_accum_writeback;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned CH     = 4;
  localparam int unsigned N      = ROWS * CH;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned SHIFT  = 4;
  localparam int unsigned IDX_W  = 4;

`ifdef OA_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic                     i_clk = 1'b0;
  logic                     i_rst;
  logic                     i_pe_finish;
  logic [N*DATA_W-1:0]      i_pe_oa;
  logic                     i_first;
  logic                     i_last;
  logic                     o_busy;
  logic                     o_valid;
  logic                     i_ready;
  logic signed [OUT_W-1:0]  o_data;
  logic [IDX_W-1:0]         o_idx;
  logic                     o_done;
  logic                     o_err;

  oa_accum_writeback #(
    .ROWS(ROWS), .CH(CH), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pe_finish(i_pe_finish), .i_pe_oa(i_pe_oa),
    .i_first(i_first), .i_last(i_last), .o_busy(o_busy), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_idx(o_idx), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [DATA_W-1:0] ps    [N];
  logic signed [OUT_W-1:0]  exp_d [N];

  // Rounding corners: psum values and their hand-computed requant results
  int mix_ps  [N] = '{24, 23, -8, -9, 2039, 2040, -2048, -2057, 0, 1, 7, 8, -1, -16, -17, 100};
  int mix_exp [N] = '{ 2,  1,  0, -1,  127,  127,  -128,  -128, 0, 0, 0, 1,  0,  -1,  -1,   6};

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load_ps();
    for (int k = 0; k < N; k++) i_pe_oa[k*DATA_W +: DATA_W] = ps[k];
  endtask

  task automatic clear_tile();
    for (int k = 0; k < N; k++) begin
      ps[k]    = '0;
      exp_d[k] = '0;
    end
  endtask

  task automatic set_ramp();
    for (int k = 0; k < N; k++) begin
      ps[k]    = DATA_W'(k * 16);
      exp_d[k] = OUT_W'(k);
    end
  endtask

  task automatic run_pass(input bit first, input bit last);
    load_ps();
    i_first     = first;
    i_last      = last;
    i_pe_finish = 1'b1;
    tick();
    i_pe_finish = 1'b0;
    tick();
  endtask

  // Consume up to 'limit' beats; rnd selects 50% random ready
  task automatic drain(input bit rnd, input int limit);
    int beat;
    int cyc;
    bit stalled;
    logic signed [OUT_W-1:0] pd;
    logic [IDX_W-1:0] pi;
    beat = 0; cyc = 0; stalled = 1'b0; pd = '0; pi = '0;
    while (beat < limit && cyc < 400) begin
      i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge i_clk);
      check("drain_valid", o_valid, 1);
      check("done_early", o_done, 0);
      if (stalled) begin
        check("hold_data", o_data, pd);
        check("hold_idx", o_idx, pi);
      end
      if (o_valid && i_ready) begin
        check("beat_idx", o_idx, beat);
        check("beat_data", o_data, exp_d[beat]);
        beat++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pd = o_data;
        pi = o_idx;
      end
      @(posedge i_clk);
      #1;
      cyc++;
    end
    i_ready = 1'b0;
    if (beat < limit) check("drain_timeout", beat, limit);
    if (limit == N) begin
      check("done_pulse", o_done, 1);
      check("valid_off", o_valid, 0);
      check("busy_off", o_busy, 0);
      check("idx_wrap", o_idx, 0);
      tick();
      check("done_1cyc", o_done, 0);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_pe_finish = 1'b0; i_pe_oa = '0; i_first = 1'b0; i_last = 1'b0; i_ready = 1'b0;
    clear_tile();
    repeat (2) tick();
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_idx", o_idx, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    i_rst = 1'b0;
    tick();

    // Uniform single-pass tile, with capture-to-valid latency
    for (int k = 0; k < N; k++) begin
      ps[k] = 16'sd32;
      exp_d[k] = 8'sd2;
    end
    load_ps();
    i_first = 1'b1; i_last = 1'b1; i_pe_finish = 1'b1;
    tick();
    i_pe_finish = 1'b0;
    check("lat1_valid", o_valid, 0);
    check("lat1_busy", o_busy, 1);
    tick();
    check("lat2_valid", o_valid, 1);
    drain(1'b0, N);

    // Rounding and output saturation corners
    for (int k = 0; k < N; k++) begin
      ps[k]    = DATA_W'(mix_ps[k]);
      exp_d[k] = (RELU && mix_ps[k] < 0) ? 8'sd0 : OUT_W'(mix_exp[k]);
    end
    run_pass(1'b1, 1'b1);
    drain(1'b0, N);

    // Two-pass accumulation, no drain after the non-last pass
    clear_tile();
    ps[0] = 16'sd100;
    run_pass(1'b1, 1'b0);
    check("nolast_busy", o_busy, 0);
    check("nolast_valid", o_valid, 0);
    repeat (3) tick();
    check("nolast_valid2", o_valid, 0);
    ps[0] = 16'sd60;
    exp_d[0] = 8'sd10;
    run_pass(1'b0, 1'b1);
    drain(1'b0, N);

    // Three negative passes -> output saturates low (or 0 with relu)
    clear_tile();
    ps[3] = -16'sd3000;
    run_pass(1'b1, 1'b0);
    run_pass(1'b0, 1'b0);
    run_pass(1'b0, 1'b1);
    exp_d[3] = RELU ? 8'sd0 : -8'sd128;
    drain(1'b0, N);

    // Accumulator saturation over 600 passes; elements 2/3 would flip sign if wrapped
    clear_tile();
    ps[0] = 16'sd32767;
    ps[1] = 16'sh8000;
    ps[2] = 16'sd16384;
    ps[3] = -16'sd16384;
    run_pass(1'b1, 1'b0);
    for (int p = 0; p < 598; p++) run_pass(1'b0, 1'b0);
    run_pass(1'b0, 1'b1);
    exp_d[0] = 8'sd127;
    exp_d[1] = RELU ? 8'sd0 : -8'sd128;
    exp_d[2] = 8'sd127;
    exp_d[3] = RELU ? 8'sd0 : -8'sd128;
    drain(1'b0, N);

    // Random backpressure
    set_ramp();
    run_pass(1'b1, 1'b1);
    drain(1'b1, N);

    // Capture while draining: sticky error, tile untouched
    set_ramp();
    run_pass(1'b1, 1'b1);
    check("err_pre", o_err, 0);
    for (int k = 0; k < N; k++) ps[k] = 16'sd1000;
    load_ps();
    i_first = 1'b1; i_last = 1'b1; i_pe_finish = 1'b1;
    tick();
    i_pe_finish = 1'b0;
    tick();
    check("err_set", o_err, 1);
    check("err_valid", o_valid, 1);
    check("err_idx", o_idx, 0);
    check("err_data", o_data, 0);
    set_ramp();
    drain(1'b0, N);
    check("err_sticky", o_err, 1);
    clear_tile();
    set_ramp();
    for (int k = 0; k < N; k++) ps[k] = '0;
    run_pass(1'b0, 1'b1);
    drain(1'b0, N);
    check("err_sticky2", o_err, 1);

    // Reset at beat 5, then accumulate onto the cleared accumulators
    set_ramp();
    run_pass(1'b1, 1'b1);
    drain(1'b0, 5);
    check("pre_rst_idx", o_idx, 5);
    check("pre_rst_data", o_data, 5);
    i_rst = 1'b1;
    tick();
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_data", o_data, 0);
    check("mid_rst_idx", o_idx, 0);
    check("mid_rst_done", o_done, 0);
    check("mid_rst_err", o_err, 0);
    i_rst = 1'b0;
    tick();
    set_ramp();
    run_pass(1'b0, 1'b1);
    drain(1'b0, N);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
